// File: rtl/sdio_cmd_sequencer_if.sv
// -----------------------------------------------------------------------------
// sdio_cmd_sequencer_if
//
// Purpose: transaction-layer bundle between the host model and the SDIO CMD
// line sequencer. The host (master) requests a command and reads back the
// card response and status flags. The sequencer (slave) accepts the request,
// reports progress and publishes the result.
//
// Signals:
//   start        master->slave  request a command (sampled only while idle)
//   cmd_index    master->slave  6-bit command index
//   cmd_arg      master->slave  32-bit command argument
//   resp_en      master->slave  a 48-bit response is expected
//   resp_no_crc  master->slave  skip CRC/index checks (R3/R4 style)
//   busy         slave->master  high from accept until done
//   done         slave->master  one-cycle completion pulse
//   resp_index   slave->master  response bits [45:40]
//   resp_arg     slave->master  response bits [39:8]
//   err_*        slave->master  status flags, valid with done, held until next accept
// -----------------------------------------------------------------------------
interface sdio_cmd_sequencer_if;
  logic        start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        resp_en;
  logic        resp_no_crc;
  logic        busy;
  logic        done;
  logic [5:0]  resp_index;
  logic [31:0] resp_arg;
  logic        err_timeout;
  logic        err_crc;
  logic        err_frame;
  logic        err_index;

  modport master (
    output start, cmd_index, cmd_arg, resp_en, resp_no_crc,
    input  busy, done, resp_index, resp_arg,
           err_timeout, err_crc, err_frame, err_index
  );

  modport slave (
    input  start, cmd_index, cmd_arg, resp_en, resp_no_crc,
    output busy, done, resp_index, resp_arg,
           err_timeout, err_crc, err_frame, err_index
  );
endinterface

// File: rtl/sdio_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// sdio_cmd_sequencer
//
// Purpose: host-side SDIO CMD line engine. Serialises a 48-bit command frame
// (start, transmission bit, index, argument, CRC7, end bit) MSB first, turns
// the line around, optionally waits for and deserialises the card's 48-bit
// response, checks its framing/CRC7/index, then idles for NCC_CYCLES before
// pulsing done.
//
// Ports:
//   sdio_clk    SDIO clock, all logic on the rising edge
//   rst_n       asynchronous active-low reset (aborts any transaction)
//   host        transaction-layer interface (slave modport)
//   sd_cmd_in   CMD pad input value
//   sd_cmd_dir  1 = host drives CMD
//   sd_cmd_out  value driven onto CMD
//
// Parameters:
//   RESP_TIMEOUT  max cycles from line release to response start bit
//   NCC_CYCLES    idle cycles after each transaction before done (>= 1)
// -----------------------------------------------------------------------------
module sdio_cmd_sequencer #(
  parameter int RESP_TIMEOUT = 64,
  parameter int NCC_CYCLES   = 8
) (
  input  logic                 sdio_clk,
  input  logic                 rst_n,
  sdio_cmd_sequencer_if.slave  host,
  input  logic                 sd_cmd_in,
  output logic                 sd_cmd_dir,
  output logic                 sd_cmd_out
);

  // One shared counter covers frame bits, the response wait and the gap.
  localparam int MAX_CNT = (RESP_TIMEOUT > 48)
                         ? ((RESP_TIMEOUT > NCC_CYCLES) ? RESP_TIMEOUT : NCC_CYCLES)
                         : ((NCC_CYCLES > 48) ? NCC_CYCLES : 48);
  localparam int CNT_W = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] TX_LAST   = CNT_W'(47);
  localparam logic [CNT_W-1:0] RX_LAST   = CNT_W'(46);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RESP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(NCC_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SEND, TURN, WAIT, RECV, GAP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [47:0]      tx_shift;
  logic [45:0]      rx_shift;
  logic [5:0]       idx_q;
  logic             resp_en_q;
  logic             no_crc_q;

  logic [39:0]      tx_head;
  logic [47:0]      tx_frame;
  logic [47:0]      rx_word;

  // CRC7 (x^7 + x^3 + 1, init 0) over a 40-bit frame head, MSB first.
  function automatic logic [6:0] crc7_40(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], fb};
      c[3] = c[3] ^ fb;
    end
    return c;
  endfunction

  // Frame to send is built straight from the live request inputs so it can
  // be loaded on the accept edge. The received word places the implicit
  // start bit (0) on top, 46 shifted bits, and the end bit still on the pad.
  always_comb begin
    tx_head  = {2'b01, host.cmd_index, host.cmd_arg};
    tx_frame = {tx_head, crc7_40(tx_head), 1'b1};
    rx_word  = {1'b0, rx_shift, sd_cmd_in};
  end

  // Single sequencer FSM with registered pad and status outputs. The SEND
  // state runs 48 edges: 47 frame bits after the one loaded at accept, then
  // one filler '1' that becomes the TURN cycle (line still driven high).
  // Accept is blocked while done is high so a start held over the done
  // cycle cannot re-trigger immediately.
  always_ff @(posedge sdio_clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      tx_shift         <= '1;
      rx_shift         <= '0;
      idx_q            <= '0;
      resp_en_q        <= 1'b0;
      no_crc_q         <= 1'b0;
      sd_cmd_dir       <= 1'b0;
      sd_cmd_out       <= 1'b1;
      host.busy        <= 1'b0;
      host.done        <= 1'b0;
      host.resp_index  <= '0;
      host.resp_arg    <= '0;
      host.err_timeout <= 1'b0;
      host.err_crc     <= 1'b0;
      host.err_frame   <= 1'b0;
      host.err_index   <= 1'b0;
    end else begin
      host.done <= 1'b0;
      case (state)
        IDLE: begin
          if (host.start && !host.done) begin
            idx_q            <= host.cmd_index;
            resp_en_q        <= host.resp_en;
            no_crc_q         <= host.resp_no_crc;
            host.resp_index  <= '0;
            host.resp_arg    <= '0;
            host.err_timeout <= 1'b0;
            host.err_crc     <= 1'b0;
            host.err_frame   <= 1'b0;
            host.err_index   <= 1'b0;
            host.busy        <= 1'b1;
            sd_cmd_dir       <= 1'b1;
            sd_cmd_out       <= tx_frame[47];
            tx_shift         <= {tx_frame[46:0], 1'b1};
            cnt              <= '0;
            state            <= SEND;
          end
        end
        SEND: begin
          sd_cmd_out <= tx_shift[47];
          tx_shift   <= {tx_shift[46:0], 1'b1};
          if (cnt == TX_LAST) begin
            cnt   <= '0;
            state <= TURN;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        TURN: begin
          sd_cmd_dir <= 1'b0;
          sd_cmd_out <= 1'b1;
          cnt        <= '0;
          state      <= resp_en_q ? WAIT : GAP;
        end
        WAIT: begin
          // A start bit on the final wait edge still wins over the timeout.
          if (!sd_cmd_in) begin
            cnt   <= '0;
            state <= RECV;
          end else if (cnt == WAIT_LAST) begin
            host.err_timeout <= 1'b1;
            cnt              <= '0;
            state            <= GAP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RECV: begin
          if (cnt == RX_LAST) begin
            host.resp_index <= rx_word[45:40];
            host.resp_arg   <= rx_word[39:8];
            host.err_frame  <= rx_word[46] | ~rx_word[0];
            host.err_crc    <= !no_crc_q && (crc7_40(rx_word[47:8]) != rx_word[7:1]);
            host.err_index  <= !no_crc_q && (rx_word[45:40] != idx_q);
            cnt             <= '0;
            state           <= GAP;
          end else begin
            rx_shift <= {rx_shift[44:0], sd_cmd_in};
            cnt      <= cnt + CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            host.done <= 1'b1;
            host.busy <= 1'b0;
            cnt       <= '0;
            state     <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sdio_cmd_sequencer.md
# sdio_cmd_sequencer

Host-side SDIO command-line engine that serialises one 48-bit command frame onto the CMD pad, releases the line, waits for and deserialises the card's 48-bit response, and checks its framing and CRC7. It sits between the host model's transaction layer and the CMD pad driver pair (`sd_cmd_coco_dir` / `sd_cmd_coco_out`), replacing per-bit software toggling with a cycle-exact hardware sequencer clocked by `sdio_clk`.

## Interface
- `RESP_TIMEOUT`, 64: maximum cycles from line release to the response start bit (NCR limit).
- `NCC_CYCLES`, 8: idle cycles inserted after each transaction before `done`.
- `sdio_clk` input 1: SDIO clock; all logic on its rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `start` input 1: request a command; sampled only in IDLE.
- `cmd_index` input 6: command index, captured at accept.
- `cmd_arg` input 32: command argument, captured at accept.
- `resp_en` input 1: expect a 48-bit response; captured at accept.
- `resp_no_crc` input 1: skip CRC and index checks (R3/R4); captured at accept.
- `sd_cmd_in` input 1: CMD pad value.
- `sd_cmd_dir` output 1: 1 = host drives CMD.
- `sd_cmd_out` output 1: value driven on CMD.
- `busy` output 1: high from accept until `done`.
- `done` output 1: one-cycle completion pulse.
- `resp_index` output 6: response bits [45:40].
- `resp_arg` output 32: response bits [39:8].
- `err_timeout`, `err_crc`, `err_frame`, `err_index` outputs 1 each: status flags, valid with `done`, held until the next accept.

## Operation
- Reset values: `sd_cmd_dir`=0, `sd_cmd_out`=1, `busy`=0, `done`=0, `resp_*`=0, all `err_*`=0, state IDLE.
- States: IDLE → SEND → TURN → (WAIT → RECV) → GAP → IDLE.
- IDLE: when `start`=1, latch the inputs, clear `err_*` and `resp_*`, and go to SEND. `start` is ignored outside IDLE.
- SEND: 48 bits MSB first: 0, 1, `cmd_index`, `cmd_arg`, CRC7, 1. `sd_cmd_dir`=1.
- CRC7: polynomial x^7+x^3+1, initial value 0, computed over the first 40 bits of the frame.
- TURN: one cycle with `sd_cmd_dir`=1 and `sd_cmd_out`=1. Then `dir` drops to 0. If `resp_en`=1 go to WAIT, else go to GAP.
- WAIT: counter from 0. The first cycle with `sd_cmd_in`=0 is the response start bit; go to RECV. If the counter reaches `RESP_TIMEOUT` first, set `err_timeout` and go to GAP.
- RECV: shift in the remaining 47 bits.
  - `err_frame` if the transmission bit (bit 46) ≠ 0 or the end bit ≠ 1.
  - Unless `resp_no_crc`: `err_crc` if the CRC7 over bits 47..8 ≠ bits 7..1; `err_index` if `resp_index` ≠ the latched `cmd_index`.
- GAP: `NCC_CYCLES` cycles with the line released. On exiting GAP, pulse `done` and return to IDLE.
- A reset mid-transaction aborts immediately: line released, no `done`.

## Timing
- Accept on edge N: `busy`=1 and first frame bit (0) on `sd_cmd_out` at N+1; frame bits occupy N+1..N+48; TURN at N+49; `sd_cmd_dir`=0 from N+50.
- No response (`resp_en`=0): GAP at N+50..N+49+`NCC_CYCLES`; `done`=1 and `busy`=0 at N+50+`NCC_CYCLES` (N+58 with defaults).
- Response start sampled at edge S: end bit sampled at S+47; flags and `resp_*` valid at S+48; GAP follows; `done` at S+48+`NCC_CYCLES`.
- Timeout: `err_timeout` set at N+50+`RESP_TIMEOUT`.
- A start bit on the same edge the counter hits the limit counts as a response, not a timeout.
- `start` asserted on the `done` cycle is ignored; the next accept is possible one cycle later.

## Test plan
- CMD0, arg 0x00000000, `resp_en`=0 → `sd_cmd_out` serialises 0x400000000095; `done` 58 cycles after accept; no errors.
- CMD17, arg 0, `resp_en`=1 → frame 0x510000000055. Card returns 0x110000090067 after 5 cycles → `resp_index`=0x11, `resp_arg`=0x00000900, no errors.
- Same as above with one argument bit flipped in the response → `err_crc`=1 and `resp_arg` shows the flipped value. Same with index 0x12 and valid CRC → `err_index`=1 only.
- `resp_en`=1, CMD held high → `err_timeout`=1 at accept+114; `done` 8 cycles later; `sd_cmd_dir` stays 0.
- R3-style response with CRC field 0x7F and `resp_no_crc`=1 → no `err_crc`/`err_index`. Response end bit 0 → `err_frame`=1.
- `rst_n` pulsed low at bit 20 of SEND → `sd_cmd_dir`=0, `sd_cmd_out`=1, `busy`=0 asynchronously; no `done`; a new `start` afterwards sends a clean frame.
